// File: rtl/spi_debug_pkg.sv
// Shared command codes and frame-state encoding for the SPI debug target.
package spi_debug_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] MISO_UNDERRUN = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DUMMY,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with a configurable idle (reset) level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= {STAGES{RESET_VAL}};
    else     stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/spi_debug_target.sv
// SPI mode-0 slave that turns read/write frames into single-access CPU-bus cycles,
// with one-byte read prefetch and sticky overrun/underrun reporting.
module spi_debug_target
  import spi_debug_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [15:0] bus_address_out,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_wait,
  output logic        err
);

  logic sclk_s, cs_n_s, mosi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

  state_e      state_q, state_d;
  logic        sclk_prev_q, sclk_prev_d, cs_n_prev_q, cs_n_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d, shift_out_q, shift_out_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d, prefetch_q, prefetch_d;
  logic        cmd_pend_q, cmd_pend_d, is_read_q, is_read_d, pf_valid_q, pf_valid_d;
  logic [15:0] addr_q, addr_d, bus_addr_q, bus_addr_d;
  logic [7:0]  bus_data_q, bus_data_d;
  logic        bus_read_q, bus_read_d, bus_write_q, bus_write_d;
  logic        err_q, err_d, miso_q, miso_d, miso_oe_q, miso_oe_d;

  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       busy, bus_done, byte_done, frame_owns_bus;
  logic [7:0] rx_byte;

  assign sclk_rise      = sclk_s & ~sclk_prev_q;
  assign sclk_fall      = ~sclk_s & sclk_prev_q;
  assign cs_fall        = ~cs_n_s & cs_n_prev_q;
  assign cs_rise        = cs_n_s & ~cs_n_prev_q;
  assign busy           = bus_read_q | bus_write_q;
  assign bus_done       = busy & ~bus_wait;
  assign rx_byte        = {shift_in_q[6:0], mosi_s};
  assign byte_done      = sclk_rise && (state_q != ST_IDLE) && (bit_cnt_q == 3'd7);
  // Accesses left over from an earlier frame must not touch this frame's address or prefetch.
  assign frame_owns_bus = (state_q == ST_WDATA) || (state_q == ST_DUMMY) || (state_q == ST_RDATA);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d     = state_q;     sclk_prev_d = sclk_s;      cs_n_prev_d = cs_n_s;
    bit_cnt_d   = bit_cnt_q;   shift_in_d  = shift_in_q;  shift_out_d = shift_out_q;
    cmd_byte_d  = cmd_byte_q;  cmd_pend_d  = cmd_pend_q;  is_read_d   = is_read_q;
    addr_d      = addr_q;      prefetch_d  = prefetch_q;  pf_valid_d  = pf_valid_q;
    bus_addr_d  = bus_addr_q;  bus_data_d  = bus_data_q;
    bus_read_d  = bus_read_q;  bus_write_d = bus_write_q;
    err_d       = err_q;       miso_d      = miso_q;      miso_oe_d   = miso_oe_q;

    if (sclk_rise && state_q != ST_IDLE) begin
      shift_in_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end
    if (sclk_fall && state_q != ST_IDLE) begin
      miso_d      = shift_out_q[7];
      shift_out_d = {shift_out_q[6:0], 1'b0};
    end

    if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          cmd_byte_d = rx_byte;
          cmd_pend_d = 1'b1;
        end
        ST_ADDR_HI: begin
          addr_d[15:8] = rx_byte;
          state_d      = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d[7:0] = rx_byte;
          if (is_read_q) begin
            state_d    = ST_DUMMY;
            pf_valid_d = 1'b0;
            if (!busy) begin
              bus_read_d = 1'b1;
              bus_addr_d = {addr_q[15:8], rx_byte};
            end
          end else begin
            state_d = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (busy) begin
            err_d = 1'b1;
          end else begin
            bus_write_d = 1'b1;
            bus_addr_d  = addr_q;
            bus_data_d  = rx_byte;
          end
        end
        ST_DUMMY, ST_RDATA: begin
          state_d     = ST_RDATA;
          shift_out_d = pf_valid_q ? prefetch_q : MISO_UNDERRUN;
          err_d       = err_q | ~pf_valid_q;
          pf_valid_d  = 1'b0;
          if (!busy) begin
            bus_read_d = 1'b1;
            bus_addr_d = addr_q;
          end
        end
        default: ;
      endcase
    end

    // A completing access wins over a same-cycle load so its data survives for the next byte.
    if (bus_done) begin
      bus_read_d  = 1'b0;
      bus_write_d = 1'b0;
      if (frame_owns_bus) addr_d = addr_q + 16'd1;
      if (bus_read_q && frame_owns_bus) begin
        prefetch_d = bus_data_in;
        pf_valid_d = 1'b1;
      end
    end

    // Command decode waits until any access from a previous frame has drained.
    if (state_q == ST_CMD && cmd_pend_q && !busy) begin
      cmd_pend_d = 1'b0;
      case (cmd_byte_q)
        CMD_READ:  begin state_d = ST_ADDR_HI; is_read_d = 1'b1; end
        CMD_WRITE: begin state_d = ST_ADDR_HI; is_read_d = 1'b0; end
        default:   state_d = ST_IGNORE;
      endcase
    end

    if (cs_fall) begin
      state_d     = ST_CMD;
      bit_cnt_d   = 3'd0;
      err_d       = 1'b0;
      cmd_pend_d  = 1'b0;
      pf_valid_d  = 1'b0;
      shift_out_d = 8'h00;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b1;
    end else if (cs_rise) begin
      state_d   = ST_IDLE;
      miso_oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_prev_q <= 1'b0;     cs_n_prev_q <= 1'b1;
      bit_cnt_q   <= 3'd0;     shift_in_q  <= 8'h00;  shift_out_q <= 8'h00;
      cmd_byte_q  <= 8'h00;    cmd_pend_q  <= 1'b0;   is_read_q   <= 1'b0;
      addr_q      <= 16'h0000; prefetch_q  <= 8'h00;  pf_valid_q  <= 1'b0;
      bus_addr_q  <= 16'h0000; bus_data_q  <= 8'h00;
      bus_read_q  <= 1'b0;     bus_write_q <= 1'b0;
      err_q       <= 1'b0;     miso_q      <= 1'b0;   miso_oe_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d; cs_n_prev_q <= cs_n_prev_d;
      bit_cnt_q   <= bit_cnt_d;   shift_in_q  <= shift_in_d;  shift_out_q <= shift_out_d;
      cmd_byte_q  <= cmd_byte_d;  cmd_pend_q  <= cmd_pend_d;  is_read_q   <= is_read_d;
      addr_q      <= addr_d;      prefetch_q  <= prefetch_d;  pf_valid_q  <= pf_valid_d;
      bus_addr_q  <= bus_addr_d;  bus_data_q  <= bus_data_d;
      bus_read_q  <= bus_read_d;  bus_write_q <= bus_write_d;
      err_q       <= err_d;       miso_q      <= miso_d;      miso_oe_q   <= miso_oe_d;
    end
  end

  assign spi_miso        = miso_q;
  assign spi_miso_oe     = miso_oe_q;
  assign bus_address_out = bus_addr_q;
  assign bus_data_out    = bus_data_q;
  assign bus_read        = bus_read_q;
  assign bus_write       = bus_write_q;
  assign err             = err_q;

endmodule

// File: tb/tb_spi_debug_target.sv
// Self-checking bench: SPI host driver, waiting-memory bus responder and a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_debug_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] bus_address_out;
  logic [7:0]  bus_data_out, bus_data_in;
  logic        bus_read, bus_write, bus_wait;
  logic        err;

  spi_debug_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wait(bus_wait), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural memory behind the bus
  logic [7:0]  mem [65536];
  assign bus_data_in = mem[bus_address_out];

  int          wait_min = 0, wait_max = 0;
  int          wait_left = 0, n_access = 0;
  bit          active = 0, done_last = 0, hold_wr = 0;
  logic [15:0] hold_addr;
  logic [7:0]  hold_data;
  logic [23:0] wr_log [$];

  always @(negedge clk) begin
    if (rst) begin
      active = 0; done_last = 0; bus_wait = 1'b0;
    end else begin
      if (bus_read || bus_write)
        check("rd_wr_exclusive", 32'(bus_read & bus_write), 32'd0);
      if (done_last) begin
        done_last = 0;
        bus_wait  = 1'b0;
        check("strobe_release", 32'(bus_read | bus_write), 32'd0);
      end else if (bus_read || bus_write) begin
        if (!active) begin
          active    = 1;
          wait_left = $urandom_range(wait_max, wait_min);
          hold_addr = bus_address_out;
          hold_data = bus_data_out;
          hold_wr   = bus_write;
          n_access++;
        end else begin
          check("hold_addr", 32'(bus_address_out), 32'(hold_addr));
          check("hold_strobe", 32'({bus_read, bus_write}), 32'({~hold_wr, hold_wr}));
          if (hold_wr) check("hold_data", 32'(bus_data_out), 32'(hold_data));
        end
        if (wait_left > 0) begin
          bus_wait = 1'b1;
          wait_left--;
        end else begin
          bus_wait  = 1'b0;
          active    = 0;
          done_last = 1;
          if (hold_wr) begin
            wr_log.push_back({hold_addr, hold_data});
            mem[hold_addr] = hold_data;
          end
        end
      end else begin
        bus_wait = 1'b0;
      end
    end
  end

  // SPI host (mode 0, sclk = clk/8)
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       oe_start, err_start, oe_end;

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      r = {r[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    rx = r;
  endtask

  task automatic run_frame();
    logic [7:0] b;
    rx_q.delete();
    wr_log.delete();
    n_access = 0;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    oe_start  = spi_miso_oe;
    err_start = err;
    foreach (tx_q[i]) begin
      spi_byte(tx_q[i], b);
      rx_q.push_back(b);
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    oe_end = spi_miso_oe;
    repeat (24) @(negedge clk);
    check("oe_in_frame", 32'(oe_start), 32'd1);
    check("oe_after_frame", 32'(oe_end), 32'd0);
    check("err_cleared_at_cs_fall", 32'(err_start), 32'd0);
  endtask

  // Reference: n bytes written to a, a+1, ... modulo 64K, in order
  task automatic do_write(input logic [15:0] a, input int n);
    tx_q = '{8'h02, a[15:8], a[7:0]};
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    run_frame();
    check("wr_count", 32'(wr_log.size()), 32'(n));
    if (wr_log.size() == n)
      for (int i = 0; i < n; i++)
        check("wr_entry", 32'(wr_log[i]), 32'({16'(a + 16'(i)), tx_q[3+i]}));
    for (int i = 0; i < 3 + n; i++) check("wr_miso_zero", 32'(rx_q[i]), 32'd0);
    check("wr_err", 32'(err), 32'd0);
  endtask

  // Reference: miso is zero for 4 header bytes, then mem[a+i] modulo 64K
  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] expect_q [$];
    for (int i = 0; i < n; i++) expect_q.push_back(mem[16'(a + 16'(i))]);
    tx_q = '{8'h03, a[15:8], a[7:0], 8'($urandom)};
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    run_frame();
    for (int i = 0; i < 4; i++) check("rd_hdr_miso_zero", 32'(rx_q[i]), 32'd0);
    for (int i = 0; i < n; i++) check("rd_data", 32'(rx_q[4+i]), 32'(expect_q[i]));
    check("rd_no_writes", 32'(wr_log.size()), 32'd0);
    check("rd_err", 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; bus_wait = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({spi_miso, spi_miso_oe, bus_read, bus_write, err}), 32'd0);
    check("rst_bus_addr", 32'(bus_address_out), 32'd0);
    check("rst_bus_data", 32'(bus_data_out), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_outputs", 32'({spi_miso, spi_miso_oe, bus_read, bus_write, err}), 32'd0);

    // Directed two-byte write with no wait
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hAA, 8'hBB};
    run_frame();
    check("w1234_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("w1234_first", 32'(wr_log[0]), 32'h1234AA);
      check("w1234_second", 32'(wr_log[1]), 32'h1235BB);
    end
    check("w1234_err", 32'(err), 32'd0);

    // Read wrapping from 0xFFFF to 0x0000
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hC3;
    tx_q = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    run_frame();
    check("wrap_byte0", 32'(rx_q[4]), 32'h5A);
    check("wrap_byte1", 32'(rx_q[5]), 32'hC3);
    check("wrap_err", 32'(err), 32'd0);

    // Fixed 4-cycle wait on every access
    wait_min = 4; wait_max = 4;
    do_read(16'(($urandom)), 3);
    do_write(16'(($urandom)), 2);

    // Wait longer than a byte time: first data byte underruns
    wait_min = 100; wait_max = 100;
    tx_q = '{8'h03, 8'h20, 8'h00, 8'h00, 8'h00};
    run_frame();
    check("underrun_byte", 32'(rx_q[4]), 32'hFF);
    check("underrun_err", 32'(err), 32'd1);
    wait_min = 0; wait_max = 0;
    do_read(16'h3000, 2);

    // Unknown command: no bus activity, miso held low
    tx_q = '{8'h9F, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame();
    check("ignore_accesses", 32'(n_access), 32'd0);
    foreach (rx_q[i]) check("ignore_miso_zero", 32'(rx_q[i]), 32'd0);
    check("ignore_err", 32'(err), 32'd0);

    // Reset while a write is held by bus_wait
    begin
      logic [7:0] b;
      wait_min = 40; wait_max = 40;
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      spi_byte(8'h02, b);
      spi_byte(8'h43, b);
      spi_byte(8'h21, b);
      spi_byte(8'hA5, b);
      for (int k = 0; k < 16 && !bus_write; k++) @(negedge clk);
      check("pre_rst_write_high", 32'(bus_write), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_outputs", 32'({spi_miso, spi_miso_oe, bus_read, bus_write, err}), 32'd0);
      check("midrst_bus_addr", 32'(bus_address_out), 32'd0);
      check("midrst_bus_data", 32'(bus_data_out), 32'd0);
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_min = 0; wait_max = 0;
      repeat (8) @(negedge clk);
      do_write(16'h5678, 2);
    end

    // Randomised frames against the reference model
    for (int t = 0; t < 16; t++) begin
      logic [15:0] a;
      int          n, kind;
      wait_min = 0;
      wait_max = $urandom_range(6, 0);
      a    = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
      n    = $urandom_range(4, 1);
      kind = $urandom_range(2, 0);
      if (kind == 0) do_write(a, n);
      else if (kind == 1) do_read(a, n);
      else begin
        logic [7:0] c;
        c = 8'($urandom);
        if (c == 8'h02 || c == 8'h03) c = 8'h9F;
        tx_q = '{c, 8'($urandom), 8'($urandom)};
        run_frame();
        check("rand_ignore_accesses", 32'(n_access), 32'd0);
        foreach (rx_q[i]) check("rand_ignore_miso", 32'(rx_q[i]), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_debug_target.md
SPI_DEBUG_TARGET -- requirements
Module: spi_debug_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages used to synchronise sclk, cs_n and mosi into clk.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous reset, active-high.
REQ-004 Port spi_sclk, input, 1 bit: external SPI clock, mode 0, asynchronous to clk, at most clk/8.
REQ-005 Port spi_cs_n, input, 1 bit: chip select, active-low.
REQ-006 Port spi_mosi, input, 1 bit: host-to-target data, MSB first.
REQ-007 Port spi_miso, output, 1 bit: target-to-host data, MSB first.
REQ-008 Port spi_miso_oe, output, 1 bit: miso output enable; high only while cs_n is low (synchronised).
REQ-009 Port bus_address_out, output, 16 bits: CPU-bus address.
REQ-010 Port bus_data_out, output, 8 bits: write data.
REQ-011 Port bus_data_in, input, 8 bits: read data.
REQ-012 Port bus_read, output, 1 bit: read strobe.
REQ-013 Port bus_write, output, 1 bit: write strobe.
REQ-014 Port bus_wait, input, 1 bit: stall from the addressed target.
REQ-015 Port err, output, 1 bit: sticky overrun or underrun flag.

Function
REQ-016 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flip-flops; edges are detected on the synchronised copies.
REQ-017 mosi SHALL be sampled on the detected sclk rise; miso SHALL change only on the detected sclk fall or on a cs_n fall.
REQ-018 Frame FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DUMMY, WDATA, RDATA, IGNORE.
REQ-019 A cs_n fall SHALL enter CMD, clear the bit counter and clear err.
REQ-020 A cs_n rise SHALL force IDLE from any state; a partial byte is discarded.
REQ-021 Each state consumes 8 rising edges, then moves on.
- CMD: 0x03 goes to ADDR_HI (read flag set); 0x02 goes to ADDR_HI (write flag set); any other value goes to IGNORE.
- ADDR_HI goes to ADDR_LO; ADDR_LO goes to DUMMY for a read, or WDATA for a write.
- DUMMY goes to RDATA.
- WDATA and RDATA loop on themselves until cs_n rises.
- IGNORE stays in IGNORE until cs_n rises.
REQ-022 Bus handshake: a strobe plus address (and data for writes) SHALL be held stable until the first clk edge on which bus_wait is low. That edge completes the access and captures bus_data_in. The strobe deasserts on the next cycle.
REQ-023 At most one bus access SHALL be in flight; bus_read and bus_write are never high together.
REQ-024 Write path: each completed WDATA byte launches a write to the current address. The address increments by 1 after completion, wrapping 0xFFFF to 0x0000.
REQ-025 If a WDATA byte completes while the previous write is still in flight, the byte SHALL be dropped and err set.
REQ-026 Read path: ADDR_LO completion launches a read of the address into the prefetch buffer, then the address increments.
REQ-027 At each byte boundary in DUMMY and RDATA, the shifter loads the prefetch buffer and the next read launches.
REQ-028 If the prefetch is not yet valid at a load, the shifter loads 0xFF and err is set.
REQ-029 miso SHALL be 0 in CMD, ADDR_HI, ADDR_LO and IGNORE, and during the DUMMY byte.
REQ-030 A cs_n rise SHALL NOT abort an in-flight bus access; the access completes per REQ-022 and its read data is discarded.
REQ-031 An in-flight access SHALL block CMD decode of a new frame until it completes.

Reset
REQ-032 On rst high, immediately and for its duration:
- FSM in IDLE; all synchronisers set to their idle levels (sclk 0, cs_n 1, mosi 0).
- spi_miso=0, spi_miso_oe=0.
- bus_read=0, bus_write=0, bus_address_out=0x0000, bus_data_out=0x00.
- err=0; prefetch buffer invalid.
REQ-033 Reset mid-frame or mid-access SHALL abandon all state; there is no completion obligation.

Structure
REQ-034 Command codes (0x03, 0x02) and the FSM state encoding SHALL live in a shared package, spi_debug_pkg.
REQ-035 The input synchroniser SHALL be one sub-module, sync_ff (parameter STAGES), instantiated three times.

Verification
REQ-036 Write 02 12 34 AA BB with wait=0 -> two writes: 0x1234=0xAA, then 0x1235=0xBB; err=0.
REQ-037 Read 03 FF FF, dummy, then 2 bytes; memory 0xFFFF=0x5A, 0x0000=0xC3 -> miso returns 5A, C3 (wrap); err=0.
REQ-038 Read with bus_wait held high for 4 cycles per access at sclk=clk/8 -> data correct, strobes held stable while wait is high.
REQ-039 Read with bus_wait held high for longer than one byte time -> miso byte 0xFF; err=1; cleared by the next cs_n fall.
REQ-040 Command 0x9F then 3 bytes -> no bus strobes, miso=0 throughout.
REQ-041 rst pulsed mid-WDATA with bus_write high -> all outputs at reset values on the same cycle; the next frame executes normally.
